// File: rtl/clint_pkg.sv
// Shared constants, types and helpers for the core-local interruptor.
package clint_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STRB_W     = DATA_W / 8;
    localparam int unsigned OFF_W      = 16;
    localparam int unsigned TIME_W     = 64;
    localparam int unsigned TICK_CNT_W = 16;

    // Low bits inside the 64 KiB window; the rest must match the base.
    localparam logic [ADDR_W-1:0] WIN_MASK = 32'h0000_FFFF;

    localparam logic [OFF_W-1:0] OFF_MSIP        = 16'h0000;
    localparam logic [OFF_W-1:0] OFF_MTIMECMP_LO = 16'h4000;
    localparam logic [OFF_W-1:0] OFF_MTIMECMP_HI = 16'h4004;
    localparam logic [OFF_W-1:0] OFF_MTIME_LO    = 16'hBFF8;
    localparam logic [OFF_W-1:0] OFF_MTIME_HI    = 16'hBFFC;

    localparam logic [TIME_W-1:0] MTIMECMP_RST = '1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_TIME_LO,
        REG_TIME_HI,
        REG_NONE
    } reg_sel_e;

    // Response payload held while waiting for resp_ready.
    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } resp_t;

    // Byte-lane merge: enabled lanes take new data, others keep old.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        for (int i = 0; i < int'(STRB_W); i++) begin
            res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// Divides clk into a one-cycle tick every TICK_DIV cycles.
module clint_tick_gen
    import clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam logic [TICK_CNT_W-1:0] CNT_MAX = TICK_CNT_W'(TICK_DIV - 1);

    logic [TICK_CNT_W-1:0] cnt_q;
    logic [TICK_CNT_W-1:0] cnt_d;
    logic                  tick_q;

    // Next counter value, wrapping at TICK_DIV-1.
    always_comb begin
        cnt_d = cnt_q + TICK_CNT_W'(1);
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end
    end

    // Counter and registered tick; tick is high while the counter sits at CNT_MAX.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= (CNT_MAX == '0);
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == CNT_MAX);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/clint_ctrl.sv
// Core-local interruptor: msip, mtime and mtimecmp behind a valid/ready port.
module clint_ctrl
    import clint_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned       TICK_DIV  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mtip,
    output logic              msip
);

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    resp_t             resp_q, resp_d;

    logic [TIME_W-1:0] mtime_q, mtime_d, mtime_inc;
    logic [TIME_W-1:0] mtimecmp_q, mtimecmp_d;
    logic [DATA_W-1:0] hi_shadow_q, hi_shadow_d;
    logic              msip_q, msip_d;
    logic              mtip_q;

    logic              tick;
    logic              accept;
    logic              wr_en;
    logic              in_window;
    logic [OFF_W-1:0]  offset;
    reg_sel_e          reg_sel;
    logic [DATA_W-1:0] rd_data;

    clint_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign accept = req_valid && (state_q == ST_IDLE);
    assign wr_en  = accept && req_we;

    // Address decode; misaligned or unmapped addresses select nothing.
    always_comb begin
        in_window = ((req_addr & ~WIN_MASK) == (BASE_ADDR & ~WIN_MASK));
        offset    = req_addr[OFF_W-1:0];
        reg_sel   = REG_NONE;
        if (in_window && (req_addr[1:0] == 2'b00)) begin
            case (offset)
                OFF_MSIP:        reg_sel = REG_MSIP;
                OFF_MTIMECMP_LO: reg_sel = REG_CMP_LO;
                OFF_MTIMECMP_HI: reg_sel = REG_CMP_HI;
                OFF_MTIME_LO:    reg_sel = REG_TIME_LO;
                OFF_MTIME_HI:    reg_sel = REG_TIME_HI;
                default:         reg_sel = REG_NONE;
            endcase
        end
    end

    // Read mux; the high half of mtime comes from the shadow for tear-free reads.
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_MSIP:    rd_data = {{(DATA_W-1){1'b0}}, msip_q};
            REG_CMP_LO:  rd_data = mtimecmp_q[31:0];
            REG_CMP_HI:  rd_data = mtimecmp_q[63:32];
            REG_TIME_LO: rd_data = mtime_q[31:0];
            REG_TIME_HI: rd_data = hi_shadow_q;
            default:     rd_data = '0;
        endcase
    end

    // Handshake FSM next state and next response payload.
    always_comb begin
        state_d      = state_q;
        resp_valid_d = resp_valid_q;
        resp_d       = resp_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_d.err   = (reg_sel == REG_NONE);
                    resp_d.rdata = (req_we || (reg_sel == REG_NONE)) ? '0 : rd_data;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    resp_d       = '0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
                resp_d       = '0;
            end
        endcase
        req_ready_d = (state_d == ST_IDLE);
    end

    // FSM and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_q       <= resp_d;
        end
    end

    // Register next values; a write to mtime merges over the ticked value.
    always_comb begin
        mtime_inc   = mtime_q + TIME_W'(tick);
        mtime_d     = mtime_inc;
        mtimecmp_d  = mtimecmp_q;
        msip_d      = msip_q;
        hi_shadow_d = hi_shadow_q;
        if (wr_en) begin
            case (reg_sel)
                REG_MSIP: begin
                    if (req_wstrb[0]) begin
                        msip_d = req_wdata[0];
                    end
                end
                REG_CMP_LO:  mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], req_wdata, req_wstrb);
                REG_CMP_HI:  mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], req_wdata, req_wstrb);
                REG_TIME_LO: mtime_d[31:0]     = merge_bytes(mtime_inc[31:0], req_wdata, req_wstrb);
                REG_TIME_HI: mtime_d[63:32]    = merge_bytes(mtime_inc[63:32], req_wdata, req_wstrb);
                default: ;
            endcase
        end
        if (accept && !req_we && (reg_sel == REG_TIME_LO)) begin
            hi_shadow_d = mtime_q[63:32];
        end
    end

    // Timer, compare, shadow and software-interrupt registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mtime_q     <= '0;
            mtimecmp_q  <= MTIMECMP_RST;
            hi_shadow_q <= '0;
            msip_q      <= 1'b0;
            mtip_q      <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            hi_shadow_q <= hi_shadow_d;
            msip_q      <= msip_d;
            mtip_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_q.rdata;
    assign resp_err   = resp_q.err;
    assign mtip       = mtip_q;
    assign msip       = msip_q;

endmodule

// File: tb/tb_clint_ctrl.sv
// Scoreboard bench for clint_ctrl with TICK_DIV=1 (dut1) and TICK_DIV=4 (dut4).
module tb_clint_ctrl;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset1, reset4;
    bit          sel;
    logic        req_valid, req_we, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_valid1, req_valid4;

    logic        req_ready1, resp_valid1, resp_err1, mtip1, msip1;
    logic [31:0] resp_rdata1;
    logic        req_ready4, resp_valid4, resp_err4, mtip4, msip4;
    logic [31:0] resp_rdata4;

    assign req_valid1 = req_valid & ~sel;
    assign req_valid4 = req_valid & sel;

    clint_ctrl #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut1 (
        .clk(clk), .reset(reset1),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid1), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1),
        .mtip(mtip1), .msip(msip1)
    );

    clint_ctrl #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
        .clk(clk), .reset(reset4),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid4), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata4), .resp_err(resp_err4),
        .mtip(mtip4), .msip(msip4)
    );

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        err;
        string       name;
    } exp_t;

    exp_t q[$];

    int n_pass  = 0;
    int n_total = 0;
    int r_cyc;             // cyc value just after reset release
    logic [31:0] mt_val;   // dut1 mtime[31:0] model: mt_val + (cyc - mt_base)
    int          mt_base;

    function automatic logic [31:0] mt_now();
        return mt_val + 32'(cyc - mt_base);
    endfunction

    function automatic logic cur_ready(input bit s);
        return s ? req_ready4 : req_ready1;
    endfunction
    function automatic logic cur_valid(input bit s);
        return s ? resp_valid4 : resp_valid1;
    endfunction
    function automatic logic [31:0] cur_rdata(input bit s);
        return s ? resp_rdata4 : resp_rdata1;
    endfunction
    function automatic logic cur_err(input bit s);
        return s ? resp_err4 : resp_err1;
    endfunction
    function automatic logic cur_mtip(input bit s);
        return s ? mtip4 : mtip1;
    endfunction
    function automatic logic cur_msip(input bit s);
        return s ? msip4 : msip1;
    endfunction

    // Push the expected response, then drive the request until accepted.
    task automatic send(input bit s, input logic we, input logic [31:0] off,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic [31:0] elo, input logic [31:0] ehi,
                        input logic eerr, input string name, output int acc);
        exp_t e;
        bit   ok;
        e.lo = elo; e.hi = ehi; e.err = eerr; e.name = name;
        q.push_back(e);
        sel = s; req_we = we; req_addr = BASE + off; req_wdata = wd; req_wstrb = st;
        req_valid = 1'b1;
        ok  = 1'b0;
        acc = -1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (cur_ready(s) === 1'b1) ok = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!ok) begin
            n_total++;
            $display("FAIL %s accept: req_ready never seen within 20 cycles", name);
            void'(q.pop_back());
        end else begin
            acc = cyc;
        end
    endtask

    // Wait for the response handshake and score it against the queue head.
    task automatic wait_done(input bit s);
        exp_t        e;
        bit          done;
        logic [31:0] d;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (cur_valid(s) === 1'b1 && resp_ready === 1'b1) begin
                done = 1'b1;
                d = cur_rdata(s);
                n_total++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_resp: got rdata %h with empty scoreboard", d);
                end else begin
                    e = q.pop_front();
                    if ($isunknown(d) || d < e.lo || d > e.hi)
                        $display("FAIL %s rdata: got %h expected %h..%h", e.name, d, e.lo, e.hi);
                    else
                        n_pass++;
                    n_total++;
                    if (cur_err(s) !== e.err)
                        $display("FAIL %s err: got %b expected %b", e.name, cur_err(s), e.err);
                    else
                        n_pass++;
                end
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            n_total++;
            $display("FAIL resp_timeout: resp_valid not seen within 40 cycles");
        end
    endtask

    task automatic rd(input bit s, input logic [31:0] off, input logic [31:0] elo,
                      input logic [31:0] ehi, input logic eerr, input string name);
        int a;
        send(s, 1'b0, off, 32'h0, 4'h0, elo, ehi, eerr, name, a);
        if (a >= 0) wait_done(s);
    endtask

    task automatic wr(input bit s, input logic [31:0] off, input logic [31:0] wd,
                      input logic [3:0] st, input logic eerr, input string name);
        int a;
        send(s, 1'b1, off, wd, st, 32'h0, 32'h0, eerr, name, a);
        if (a >= 0) wait_done(s);
    endtask

    task automatic test_reset();
        reset1 = 1'b1; reset4 = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        resp_ready = 1'b1; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            n_total++;
            if (cur_ready(1'(s)) !== 1'b1) $display("FAIL reset_req_ready[%0d]: got %b expected 1", s, cur_ready(1'(s)));
            else n_pass++;
            n_total++;
            if (cur_valid(1'(s)) !== 1'b0) $display("FAIL reset_resp_valid[%0d]: got %b expected 0", s, cur_valid(1'(s)));
            else n_pass++;
            n_total++;
            if (cur_rdata(1'(s)) !== 32'h0 || cur_err(1'(s)) !== 1'b0)
                $display("FAIL reset_resp[%0d]: got %h/%b expected 0/0", s, cur_rdata(1'(s)), cur_err(1'(s)));
            else n_pass++;
            n_total++;
            if (cur_mtip(1'(s)) !== 1'b0 || cur_msip(1'(s)) !== 1'b0)
                $display("FAIL reset_irq[%0d]: got mtip %b msip %b expected 0 0", s, cur_mtip(1'(s)), cur_msip(1'(s)));
            else n_pass++;
        end
        reset1 = 1'b0; reset4 = 1'b0;
        r_cyc   = cyc;
        mt_val  = 32'h0;
        mt_base = r_cyc;
    endtask

    task automatic test_mtime_count();
        while (cyc < r_cyc + 10) begin @(posedge clk); #1; end
        n_total++;
        if (mtip1 !== 1'b0) $display("FAIL count_mtip: got %b expected 0", mtip1);
        else n_pass++;
        rd(1'b0, 32'hBFF8, 32'd10, 32'd12, 1'b0, "count_lo");
        n_total++;
        if (mtip1 !== 1'b0) $display("FAIL count_mtip_after: got %b expected 0", mtip1);
        else n_pass++;
    endtask

    task automatic test_tick_div();
        rd(1'b1, 32'hBFF8, 32'((cyc - r_cyc) / 4), 32'((cyc - r_cyc) / 4), 1'b0, "div4_lo_a");
        repeat (3) @(posedge clk);
        #1;
        rd(1'b1, 32'hBFF8, 32'((cyc - r_cyc) / 4), 32'((cyc - r_cyc) / 4), 1'b0, "div4_lo_b");
        repeat (5) @(posedge clk);
        #1;
        rd(1'b1, 32'hBFF8, 32'((cyc - r_cyc) / 4), 32'((cyc - r_cyc) / 4), 1'b0, "div4_lo_c");
        rd(1'b1, 32'hBFFC, 32'h0, 32'h0, 1'b0, "div4_hi");
    endtask

    task automatic test_reset_values();
        rd(1'b0, 32'h4000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "cmp_lo_rst");
        rd(1'b0, 32'h4004, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "cmp_hi_rst");
        rd(1'b0, 32'h0000, 32'h0, 32'h0, 1'b0, "msip_rst");
    endtask

    task automatic test_mtip();
        int ca, cd;
        wr(1'b0, 32'h4000, 32'd100, 4'hF, 1'b0, "cmp_lo_wr");
        wr(1'b0, 32'h4004, 32'd0, 4'hF, 1'b0, "cmp_hi_wr");
        n_total++;
        if (mtip1 !== 1'b0) $display("FAIL mtip_early: got %b expected 0", mtip1);
        else n_pass++;
        send(1'b0, 1'b1, 32'hBFF8, 32'd90, 4'hF, 32'h0, 32'h0, 1'b0, "mtime_lo_90", ca);
        wait_done(1'b0);
        mt_val = 32'd90; mt_base = ca;
        while (cyc < ca + 10) begin @(posedge clk); #1; end
        n_total++;
        if (mtip1 !== 1'b0) $display("FAIL mtip_at_100: got %b expected 0", mtip1);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (mtip1 !== 1'b1) $display("FAIL mtip_rise: got %b expected 1", mtip1);
        else n_pass++;
        send(1'b0, 1'b1, 32'h4004, 32'd1, 4'hF, 32'h0, 32'h0, 1'b0, "cmp_hi_1", cd);
        n_total++;
        if (mtip1 !== 1'b1) $display("FAIL mtip_hold: got %b expected 1", mtip1);
        else n_pass++;
        wait_done(1'b0);
        n_total++;
        if (mtip1 !== 1'b0) $display("FAIL mtip_fall: got %b expected 0", mtip1);
        else n_pass++;
    endtask

    task automatic test_hi_shadow_wrap();
        int cb;
        wr(1'b0, 32'hBFFC, 32'hFFFF_FFFF, 4'hF, 1'b0, "mtime_hi_wr");
        rd(1'b0, 32'hBFF8, mt_now(), mt_now(), 1'b0, "shadow_lo");
        rd(1'b0, 32'hBFFC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "shadow_hi");
        send(1'b0, 1'b1, 32'hBFF8, 32'hFFFF_FFFF, 4'hF, 32'h0, 32'h0, 1'b0, "mtime_lo_max", cb);
        wait_done(1'b0);
        mt_val = 32'hFFFF_FFFF; mt_base = cb;
        repeat (3) @(posedge clk);
        #1;
        rd(1'b0, 32'hBFF8, mt_now(), mt_now(), 1'b0, "wrap_lo");
        rd(1'b0, 32'hBFFC, 32'h0, 32'h0, 1'b0, "wrap_hi");
        n_total++;
        if (mtip1 !== 1'b0) $display("FAIL wrap_mtip: got %b expected 0", mtip1);
        else n_pass++;
    endtask

    task automatic test_tick_merge();
        int          cp;
        logic [31:0] inc;
        logic [31:0] e;
        inc = mt_now() + 32'd1;
        e   = {24'hABCDEF, inc[7:0]};
        send(1'b0, 1'b1, 32'hBFF8, 32'hABCD_EF00, 4'b1110, 32'h0, 32'h0, 1'b0, "merge_wr", cp);
        wait_done(1'b0);
        mt_val = e; mt_base = cp;
        rd(1'b0, 32'hBFF8, mt_now(), mt_now(), 1'b0, "merge_lo");
        rd(1'b0, 32'hBFFC, 32'h0, 32'h0, 1'b0, "merge_hi");
    endtask

    task automatic test_msip();
        wr(1'b0, 32'h0000, 32'h1, 4'b0001, 1'b0, "msip_set");
        n_total++;
        if (msip1 !== 1'b1) $display("FAIL msip_set_pin: got %b expected 1", msip1);
        else n_pass++;
        rd(1'b0, 32'h0000, 32'h1, 32'h1, 1'b0, "msip_rd");
        wr(1'b0, 32'h0000, 32'h0, 4'b0000, 1'b0, "msip_nostrb");
        n_total++;
        if (msip1 !== 1'b1) $display("FAIL msip_nostrb_pin: got %b expected 1", msip1);
        else n_pass++;
        wr(1'b0, 32'h0000, 32'hFFFF_FFFE, 4'b0001, 1'b0, "msip_clr");
        n_total++;
        if (msip1 !== 1'b0) $display("FAIL msip_clr_pin: got %b expected 0", msip1);
        else n_pass++;
    endtask

    task automatic test_errors_stall();
        int a;
        rd(1'b0, 32'h0008, 32'h0, 32'h0, 1'b1, "err_0008");
        rd(1'b0, 32'h4002, 32'h0, 32'h0, 1'b1, "err_4002");
        rd(1'b0, 32'h0001_4000, 32'h0, 32'h0, 1'b1, "err_window");
        wr(1'b0, 32'h4001, 32'h0, 4'hF, 1'b1, "err_wr_misaligned");
        rd(1'b0, 32'h4000, 32'd100, 32'd100, 1'b0, "cmp_lo_intact");
        resp_ready = 1'b0;
        send(1'b0, 1'b0, 32'h0008, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, "stall_err", a);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_total++;
            if (resp_valid1 !== 1'b1 || resp_rdata1 !== 32'h0 || resp_err1 !== 1'b1 || req_ready1 !== 1'b0)
                $display("FAIL stall_err[%0d]: got v%b d%h e%b r%b expected v1 d0 e1 r0",
                         i, resp_valid1, resp_rdata1, resp_err1, req_ready1);
            else n_pass++;
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        wait_done(1'b0);
        resp_ready = 1'b0;
        send(1'b0, 1'b0, 32'h4000, 32'h0, 4'h0, 32'd100, 32'd100, 1'b0, "stall_rd", a);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if (resp_valid1 !== 1'b1 || resp_rdata1 !== 32'd100 || req_ready1 !== 1'b0)
                $display("FAIL stall_rd[%0d]: got v%b d%h r%b expected v1 d64 r0",
                         i, resp_valid1, resp_rdata1, req_ready1);
            else n_pass++;
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        wait_done(1'b0);
    endtask

    task automatic test_back_to_back();
        int a;
        send(1'b0, 1'b0, 32'h4004, 32'h0, 4'h0, 32'd1, 32'd1, 1'b0, "b2b_a", a);
        n_total++;
        if (resp_valid1 !== 1'b1 || req_ready1 !== 1'b0)
            $display("FAIL b2b_latency: got v%b r%b expected v1 r0", resp_valid1, req_ready1);
        else n_pass++;
        wait_done(1'b0);
        n_total++;
        if (req_ready1 !== 1'b1) $display("FAIL b2b_idle: got %b expected 1", req_ready1);
        else n_pass++;
        rd(1'b0, 32'h4000, 32'd100, 32'd100, 1'b0, "b2b_b");
    endtask

    task automatic test_reset_in_resp();
        int a;
        resp_ready = 1'b0;
        send(1'b1, 1'b1, 32'h4000, 32'h5, 4'hF, 32'h0, 32'h0, 1'b0, "rst_pending", a);
        n_total++;
        if (resp_valid4 !== 1'b1) $display("FAIL rst_pending_valid: got %b expected 1", resp_valid4);
        else n_pass++;
        reset4 = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (resp_valid4 !== 1'b0 || req_ready4 !== 1'b1 || resp_err4 !== 1'b0 || resp_rdata4 !== 32'h0)
            $display("FAIL rst_in_resp: got v%b r%b e%b d%h expected v0 r1 e0 d0",
                     resp_valid4, req_ready4, resp_err4, resp_rdata4);
        else n_pass++;
        q.delete();
        reset4 = 1'b0;
        resp_ready = 1'b1;
        rd(1'b1, 32'h4000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "rst_cmp_restored");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mtime_count();
        test_tick_div();
        test_reset_values();
        test_mtip();
        test_hi_shadow_wrap();
        test_tick_merge();
        test_msip();
        test_errors_stall();
        test_back_to_back();
        test_reset_in_resp();
        n_total++;
        if (q.size() != 0) $display("FAIL scoreboard_drain: got %0d entries expected 0", q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
